// File: rtl/udma_rx_lin_arbiter.sv
// Round-robin arbiter that merges the uDMA linear RX channels into a single
// registered word stream for the L2 write path. The output ID is the channel ID.

module udma_rx_lin_arb_lane #(
  parameter int ID_W = 3,
  parameter int IDX  = 0
) (
  input  logic            i_valid,
  input  logic            i_en,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_elig,
  output logic            o_hi
);
  localparam logic [ID_W-1:0] LIDX = ID_W'(IDX);

  assign o_elig = i_valid && i_en;
  // o_hi marks lanes at or above the pointer, which are searched first
  assign o_hi   = (LIDX >= i_ptr);
endmodule

module udma_rx_lin_arbiter #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 32,
  parameter int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH-1:0]        ch_en_i,
  input  logic [N_CH-1:0]        ch_valid_i,
  input  logic [N_CH*DATA_W-1:0] ch_data_i,
  input  logic [N_CH*2-1:0]      ch_size_i,
  output logic [N_CH-1:0]        ch_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [1:0]             out_size_o,
  output logic [ID_W-1:0]        out_ch_id_o
);
  logic [ID_W-1:0]   r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_size;
  logic [ID_W-1:0]   r_out_id;

  logic [N_CH-1:0]   w_elig, w_hi, w_elig_hi, w_pick_src, w_gnt;
  logic              w_any, w_load, w_xfer;
  logic [ID_W-1:0]   w_gnt_id, w_ptr_nxt;
  logic [DATA_W-1:0] w_gnt_data;
  logic [1:0]        w_gnt_size;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    udma_rx_lin_arb_lane #(.ID_W(ID_W), .IDX(g)) u_lane (
      .i_valid (ch_valid_i[g]),
      .i_en    (ch_en_i[g]),
      .i_ptr   (r_ptr),
      .o_elig  (w_elig[g]),
      .o_hi    (w_hi[g])
    );
  end

  // Two-pass rotation: lowest eligible lane at/after the pointer, else lowest overall
  assign w_elig_hi  = w_elig & w_hi;
  assign w_pick_src = (|w_elig_hi) ? w_elig_hi : w_elig;
  assign w_gnt      = w_pick_src & (~w_pick_src + N_CH'(1));
  assign w_any      = |w_elig;
  assign w_load     = !r_out_valid || out_ready_i;
  assign w_xfer     = w_any && w_load && !rst_i;
  assign ch_ready_o = w_xfer ? w_gnt : '0;

  always_comb begin
    w_gnt_id   = '0;
    w_gnt_data = '0;
    w_gnt_size = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt[i]) begin
        w_gnt_id   = ID_W'(i);
        w_gnt_data = ch_data_i[i*DATA_W +: DATA_W];
        w_gnt_size = ch_size_i[2*i +: 2];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_W'(N_CH-1)) ? '0 : w_gnt_id + ID_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_size  <= '0;
      r_out_id    <= '0;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_out_data <= w_gnt_data;
        r_out_size <= w_gnt_size;
        r_out_id   <= w_gnt_id;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_size_o  = r_out_size;
  assign out_ch_id_o = r_out_id;
endmodule
